// File: rtl/core_ctrl_if.sv
// Controller-side bundle for the RV32 core controller: decode fields, memory and
// multiplier status in, sequencing strobes and status out.
interface core_ctrl_if #(
  parameter int unsigned BIT_W = 32
);
  logic [6:0]       i_OPcode;
  logic [6:0]       i_funct7;
  logic             i_IMEM_stall;
  logic             i_DMEM_stall;
  logic             i_MUL_done;
  logic             o_IMEM_cen;
  logic             o_IR_we;
  logic             o_DMEM_cen;
  logic             o_DMEM_wen;
  logic             o_MUL_valid;
  logic             o_RF_we;
  logic             o_PC_we;
  logic [3:0]       o_state;
  logic [BIT_W-1:0] o_instret;
  logic             o_finish;
  logic             o_illegal;

  // Controller end
  modport slave (
    input  i_OPcode, i_funct7, i_IMEM_stall, i_DMEM_stall, i_MUL_done,
    output o_IMEM_cen, o_IR_we, o_DMEM_cen, o_DMEM_wen, o_MUL_valid,
           o_RF_we, o_PC_we, o_state, o_instret, o_finish, o_illegal
  );

  // Datapath / memory end
  modport master (
    output i_OPcode, i_funct7, i_IMEM_stall, i_DMEM_stall, i_MUL_done,
    input  o_IMEM_cen, o_IR_we, o_DMEM_cen, o_DMEM_wen, o_MUL_valid,
           o_RF_we, o_PC_we, o_state, o_instret, o_finish, o_illegal
  );
endinterface

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle RV32 main controller: fetch/decode/execute/mul-wait/memory/writeback
// sequencing, retired-instruction counter and halt on ECALL or illegal opcode.
module core_ctrl_fsm #(
  parameter int unsigned BIT_W = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  core_ctrl_if.slave  bus
);
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    IF_REQ   = 4'd1,
    IF_WAIT  = 4'd2,
    ID       = 4'd3,
    EX       = 4'd4,
    MUL_WAIT = 4'd5,
    MEM_REQ  = 4'd6,
    MEM_WAIT = 4'd7,
    WB       = 4'd8,
    HALT     = 4'd9
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_MUL    = 7'b0000001;

  state_t           state;
  logic             is_mul, is_load, is_store, writes_rd;
  logic             imem_cen, dmem_cen, dmem_wen, mul_valid, rf_we, pc_we;
  logic             finish, illegal;
  logic [BIT_W-1:0] instret;

  logic dec_legal, dec_sys, dec_load, dec_store, dec_wr, dec_mul;

  // Opcode classification, only consumed while in ID
  always_comb begin
    dec_legal = 1'b1;
    dec_sys   = 1'b0;
    dec_load  = 1'b0;
    dec_store = 1'b0;
    dec_wr    = 1'b0;
    case (bus.i_OPcode)
      OP_R, OP_I, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: dec_wr = 1'b1;
      OP_LOAD: begin
        dec_load = 1'b1;
        dec_wr   = 1'b1;
      end
      OP_STORE:  dec_store = 1'b1;
      OP_BRANCH: dec_wr    = 1'b0;
      OP_SYSTEM: dec_sys   = 1'b1;
      default:   dec_legal = 1'b0;
    endcase
  end

  assign dec_mul = (bus.i_OPcode == OP_R) && (bus.i_funct7 == F7_MUL);

  // Strobes are registered and set on entry to the state they belong to
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      is_mul    <= 1'b0;
      is_load   <= 1'b0;
      is_store  <= 1'b0;
      writes_rd <= 1'b0;
      imem_cen  <= 1'b0;
      dmem_cen  <= 1'b0;
      dmem_wen  <= 1'b0;
      mul_valid <= 1'b0;
      rf_we     <= 1'b0;
      pc_we     <= 1'b0;
      finish    <= 1'b0;
      illegal   <= 1'b0;
      instret   <= '0;
    end else begin
      imem_cen  <= 1'b0;
      dmem_cen  <= 1'b0;
      dmem_wen  <= 1'b0;
      mul_valid <= 1'b0;
      rf_we     <= 1'b0;
      pc_we     <= 1'b0;
      case (state)
        IDLE: begin
          state    <= IF_REQ;
          imem_cen <= 1'b1;
        end
        IF_REQ: state <= IF_WAIT;
        IF_WAIT: if (!bus.i_IMEM_stall) state <= ID;
        ID: begin
          is_mul    <= dec_mul;
          is_load   <= dec_load;
          is_store  <= dec_store;
          writes_rd <= dec_wr;
          if (dec_sys || !dec_legal) begin
            state   <= HALT;
            finish  <= 1'b1;
            illegal <= !dec_legal;
          end else begin
            state     <= EX;
            mul_valid <= dec_mul;
          end
        end
        EX: begin
          if (is_mul) begin
            state <= MUL_WAIT;
          end else if (is_load || is_store) begin
            state    <= MEM_REQ;
            dmem_cen <= 1'b1;
            dmem_wen <= is_store;
          end else begin
            state   <= WB;
            pc_we   <= 1'b1;
            rf_we   <= writes_rd;
            instret <= instret + BIT_W'(1);
          end
        end
        MUL_WAIT: begin
          if (bus.i_MUL_done) begin
            state   <= WB;
            pc_we   <= 1'b1;
            rf_we   <= writes_rd;
            instret <= instret + BIT_W'(1);
          end
        end
        MEM_REQ: state <= MEM_WAIT;
        MEM_WAIT: begin
          if (!bus.i_DMEM_stall) begin
            state   <= WB;
            pc_we   <= 1'b1;
            rf_we   <= writes_rd;
            instret <= instret + BIT_W'(1);
          end
        end
        WB: begin
          state    <= IF_REQ;
          imem_cen <= 1'b1;
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_IMEM_cen  = imem_cen;
  assign bus.o_IR_we     = (state == IF_WAIT) && !bus.i_IMEM_stall;
  assign bus.o_DMEM_cen  = dmem_cen;
  assign bus.o_DMEM_wen  = dmem_wen;
  assign bus.o_MUL_valid = mul_valid;
  assign bus.o_RF_we     = rf_we;
  assign bus.o_PC_we     = pc_we;
  assign bus.o_state     = state;
  assign bus.o_instret   = instret;
  assign bus.o_finish    = finish;
  assign bus.o_illegal   = illegal;
endmodule
